// File: rtl/tft_cmd_pkg.sv
// Shared constants and state encoding for the TFT command executor.
package tft_cmd_pkg;

   // Register-command opcodes carried on cmd_opcode
   localparam logic [3:0] OPC_BASE_LO = 4'h1;
   localparam logic [3:0] OPC_BASE_HI = 4'h2;
   localparam logic [3:0] OPC_BGCOL   = 4'h3;
   localparam logic [3:0] OPC_DISPEN  = 4'h4;
   localparam logic [3:0] OPC_FILL    = 4'h5;
   localparam logic [3:0] OPC_LOAD    = 4'hF;

   // Words written by one frame fill (800x480)
   localparam int unsigned FRAME_PIX_DEF = 384000;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StFill
   } state_e;

endpackage

// File: rtl/tft_pix_fifo.sv
// Small synchronous FIFO buffering {address, pixel} write requests.
module tft_pix_fifo #(
   parameter int unsigned WIDTH      = 38,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  push_ok;
   logic                  pop_ok;

   assign full    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   // Head is read straight from the storage registers, so it is glitch-free
   assign head    = mem_q[rd_ptr_q];

   // Storage and pointer update; push and pop in one cycle leave count unchanged
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count_q <= count_q + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/tft_cmd_exec.sv
// Decodes UART register commands into TFT control registers, buffers pixel-load
// streams into SDRAM write requests and performs background-colour frame fills.
module tft_cmd_exec
   import tft_cmd_pkg::*;
#(
   parameter int unsigned       ADDR_W          = 22,
   parameter logic [ADDR_W-1:0] FRAME_PIX       = ADDR_W'(FRAME_PIX_DEF),
   parameter int unsigned       FIFO_DEPTH_LOG2 = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [3:0]        cmd_opcode,
   input  logic [15:0]       cmd_data,
   input  logic              cmd_load,
   input  logic              cmd_dat_update,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   input  logic              wr_ack,
   output logic [ADDR_W-1:0] base_addr,
   output logic [15:0]       bg_color,
   output logic              disp_en,
   output logic              busy,
   output logic              ovf_err
);

   localparam int unsigned       FifoW    = ADDR_W + 16;
   localparam logic [ADDR_W-1:0] FillLast = FRAME_PIX - ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [15:0]       bg_q;
   logic              disp_q;
   logic              load_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              ovf_q;
   logic [ADDR_W-1:0] fill_base_q;
   logic [15:0]       fill_color_q;
   logic [ADDR_W-1:0] fill_cnt_q;

   logic              reg_cmd;
   logic              load_rise;
   logic              load_start;
   logic              fill_start;
   logic              push;
   logic              pop;
   logic              fifo_sel;
   logic              fill_sel;
   logic              fill_adv;
   logic [FifoW-1:0]  fifo_head;
   logic              fifo_full;
   logic              fifo_empty;

   assign reg_cmd    = ~cmd_load & cmd_dat_update;
   assign load_rise  = cmd_load & ~load_q;
   assign load_start = load_rise & (state_q == StIdle);
   assign push       = (state_q == StLoad) & cmd_load & cmd_dat_update;

   // Buffered pixels drain ahead of the fill so a fill never overtakes them
   assign fifo_sel = ~fifo_empty;
   assign fill_sel = (state_q == StFill) & fifo_empty;
   assign pop      = fifo_sel & wr_ack;
   assign fill_adv = fill_sel & wr_ack;

   assign wr_req    = fifo_sel | fill_sel;
   assign busy      = (state_q == StFill) | ~fifo_empty;
   assign base_addr = base_q;
   assign bg_color  = bg_q;
   assign disp_en   = disp_q;
   assign ovf_err   = ovf_q;

   // Write-port mux; idle outputs are forced to zero
   always_comb begin
      wr_addr = '0;
      wr_data = '0;
      if (fifo_sel) begin
         wr_addr = fifo_head[FifoW-1:16];
         wr_data = fifo_head[15:0];
      end else if (fill_sel) begin
         wr_addr = fill_base_q + fill_cnt_q;
         wr_data = fill_color_q;
      end
   end

   // Next-state logic for the IDLE/LOAD/FILL controller
   always_comb begin
      state_d    = state_q;
      fill_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_rise) begin
               state_d = StLoad;
            end else if (reg_cmd && (cmd_opcode == OPC_FILL)) begin
               state_d    = StFill;
               fill_start = 1'b1;
            end
         end
         StLoad: begin
            if (!cmd_load) begin
               state_d = StIdle;
            end
         end
         StFill: begin
            if (fill_adv && (fill_cnt_q == FillLast)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register and cmd_load edge tracker
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         load_q  <= cmd_load;
      end
   end

   // Control registers written by register commands, in any state
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         base_q <= '0;
         bg_q   <= '0;
         disp_q <= 1'b0;
      end else if (reg_cmd) begin
         case (cmd_opcode)
            OPC_BASE_LO: base_q[15:0]        <= cmd_data;
            OPC_BASE_HI: base_q[ADDR_W-1:16] <= cmd_data[ADDR_W-17:0];
            OPC_BGCOL:   bg_q                <= cmd_data;
            OPC_DISPEN:  disp_q              <= cmd_data[0];
            default: ;
         endcase
      end
   end

   // Load-session write pointer and sticky overflow flag
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ptr_q <= '0;
         ovf_q <= 1'b0;
      end else if (load_start) begin
         ptr_q <= base_q;
         ovf_q <= 1'b0;
      end else if (push) begin
         if (fifo_full) begin
            ovf_q <= 1'b1;
         end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
         end
      end
   end

   // Fill address/colour are snapshotted at start so later commands do not disturb it
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fill_base_q  <= '0;
         fill_color_q <= '0;
         fill_cnt_q   <= '0;
      end else if (fill_start) begin
         fill_base_q  <= base_q;
         fill_color_q <= bg_q;
         fill_cnt_q   <= '0;
      end else if (fill_adv) begin
         fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
      end
   end

   tft_pix_fifo #(
      .WIDTH      (FifoW),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push      (push),
      .push_data ({ptr_q, cmd_data}),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_tft_cmd_exec.sv
// Scoreboard bench for tft_cmd_exec: stimulus pushes expected SDRAM writes,
// a negedge monitor pops and compares each acknowledged write.
module tb_tft_cmd_exec;

   localparam int unsigned AW    = 22;
   localparam int unsigned FRAME = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk;
   logic          nrst;
   logic [3:0]    cmd_opcode;
   logic [15:0]   cmd_data;
   logic          cmd_load;
   logic          cmd_dat_update;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          wr_ack;
   logic [AW-1:0] base_addr;
   logic [15:0]   bg_color;
   logic          disp_en;
   logic          busy;
   logic          ovf_err;

   int n_checks = 0;
   int n_errors = 0;
   int ack_mode = 0;  // 0: held low, 1: held high, 2: random

   // Reference model state
   logic [AW+15:0] exp_q[$];
   int unsigned    m_base = 0;
   logic [15:0]    m_bg = '0;
   logic           m_disp = 1'b0;
   logic           m_ovf = 1'b0;

   tft_cmd_exec #(
      .ADDR_W          (AW),
      .FRAME_PIX       (22'd8),
      .FIFO_DEPTH_LOG2 (2)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .cmd_opcode     (cmd_opcode),
      .cmd_data       (cmd_data),
      .cmd_load       (cmd_load),
      .cmd_dat_update (cmd_dat_update),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_ack         (wr_ack),
      .base_addr      (base_addr),
      .bg_color       (bg_color),
      .disp_en        (disp_en),
      .busy           (busy),
      .ovf_err        (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Ack driver
   initial begin
      wr_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ack_mode)
            0:       wr_ack = 1'b0;
            1:       wr_ack = 1'b1;
            default: wr_ack = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: a write happens on the next posedge when req and ack are both high
   always @(negedge clk) begin
      if (nrst && wr_req) begin
         check("busy_with_req", 64'(busy), 64'd1);
         if (wr_ack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'({wr_addr, wr_data}), 64'h0);
            end else begin
               check("write", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic check_regs();
      check("base_addr", 64'(base_addr), 64'(m_base));
      check("bg_color", 64'(bg_color), 64'(m_bg));
      check("disp_en", 64'(disp_en), 64'(m_disp));
   endtask

   // Register command; model applies the same rule and queues fill writes
   task automatic reg_cmd(input logic [3:0] op, input logic [15:0] data);
      cmd_opcode     = op;
      cmd_data       = data;
      cmd_dat_update = 1'b1;
      step();
      cmd_dat_update = 1'b0;
      case (op)
         4'h1: m_base = (m_base & 32'h3F_0000) | 32'(data);
         4'h2: m_base = (m_base & 32'h00_FFFF) | ((32'(data) & 32'h3F) << 16);
         4'h3: m_bg = data;
         4'h4: m_disp = data[0];
         4'h5: begin
            for (int i = 0; i < int'(FRAME); i++) begin
               exp_q.push_back({AW'((m_base + i) % (1 << AW)), m_bg});
            end
         end
         default: ;
      endcase
      check_regs();
   endtask

   task automatic set_base(input int unsigned b);
      reg_cmd(4'h1, b[15:0]);
      reg_cmd(4'h2, {10'd0, b[21:16]});
   endtask

   // Pixel-load session of n words on consecutive cycles; FIFO assumed empty at start
   task automatic load(input int n);
      int unsigned p;
      logic [15:0] d;
      int          acc;
      p   = m_base;
      acc = 0;
      cmd_load = 1'b1;
      step();
      for (int i = 0; i < n; i++) begin
         d              = 16'($urandom);
         cmd_opcode     = 4'hF;
         cmd_data       = d;
         cmd_dat_update = 1'b1;
         // With the port stalled, only the buffer depth can be accepted
         if (ack_mode != 0 || acc < int'(DEPTH)) begin
            exp_q.push_back({AW'(p), d});
            p = (p + 1) % (1 << AW);
            acc++;
         end
         step();
      end
      cmd_dat_update = 1'b0;
      cmd_load       = 1'b0;
      m_ovf          = (acc < n);
      step();
      check("ovf_err", 64'(ovf_err), 64'(m_ovf));
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      while ((exp_q.size() != 0 || busy) && cyc < 3000) begin
         step();
         cyc++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_wr_req"}, 64'(wr_req), 64'd0);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
      check({tag, "_base"}, 64'(base_addr), 64'd0);
      check({tag, "_bg"}, 64'(bg_color), 64'd0);
      check({tag, "_disp"}, 64'(disp_en), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_ovf"}, 64'(ovf_err), 64'd0);
   endtask

   initial begin
      int cyc;
      nrst           = 1'b0;
      cmd_opcode     = '0;
      cmd_data       = '0;
      cmd_load       = 1'b0;
      cmd_dat_update = 1'b0;
      #3;
      check_zero_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b1;
      step();

      // Basic load with ack tied high
      ack_mode = 1;
      reg_cmd(4'h1, 16'h1000);
      reg_cmd(4'h2, 16'h0002);
      check("base_21000", 64'(base_addr), 64'h21000);
      begin
         exp_q.push_back({22'h21000, 16'hA1A1});
         exp_q.push_back({22'h21001, 16'hB2B2});
         exp_q.push_back({22'h21002, 16'hC3C3});
         cmd_load = 1'b1;
         step();
         cmd_opcode     = 4'hF;
         cmd_dat_update = 1'b1;
         cmd_data = 16'hA1A1; step();
         cmd_data = 16'hB2B2; step();
         cmd_data = 16'hC3C3; step();
         cmd_dat_update = 1'b0;
         cmd_load       = 1'b0;
         step();
         check("ovf_basic", 64'(ovf_err), 64'd0);
      end
      wait_idle("drain_basic");

      // Overflow with the write port stalled
      ack_mode = 0;
      set_base(32'h00_0400);
      load(6);
      check("busy_stalled", 64'(busy), 64'd1);
      ack_mode = 1;
      wait_idle("drain_ovf");
      check("ovf_sticky", 64'(ovf_err), 64'd1);

      // Fill: busy drops right after the last ack
      ack_mode = 1;
      reg_cmd(4'h3, 16'hF800);
      set_base(32'h0);
      reg_cmd(4'h5, 16'h0000);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin
         step();
         cyc++;
      end
      check("fill_count", 64'(exp_q.size()), 64'd0);
      check("busy_after_fill", 64'(busy), 64'd0);

      // Address wrap at the top of the address space
      ack_mode = 2;
      set_base(32'h3F_FFFE);
      load(4);
      wait_idle("drain_wrap");

      // Register commands during a fill take effect at once without disturbing it
      ack_mode = 0;
      set_base(32'h00_0100);
      reg_cmd(4'h3, 16'h07E0);
      reg_cmd(4'h5, 16'h0000);
      reg_cmd(4'h4, 16'h0001);
      check("disp_mid_fill", 64'(disp_en), 64'd1);
      reg_cmd(4'h3, 16'h001F);
      reg_cmd(4'h1, 16'h0500);
      ack_mode = 2;
      wait_idle("drain_fill_latched");

      // A new session clears the sticky overflow
      load(2);
      wait_idle("drain_clear_ovf");

      // Reset mid-run with writes queued
      ack_mode = 0;
      set_base(32'h00_2000);
      load(3);
      nrst = 1'b0;
      #1;
      check_zero_outputs("midreset");
      exp_q.delete();
      m_base = 0;
      m_bg   = '0;
      m_disp = 1'b0;
      m_ovf  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      step();
      check("busy_after_reset", 64'(busy), 64'd0);
      check("req_after_reset", 64'(wr_req), 64'd0);

      // Randomised traffic against the model
      for (int it = 0; it < 10; it++) begin
         ack_mode = 2;
         set_base($urandom_range(0, 32'h3F_FFFF));
         reg_cmd(4'h3, 16'($urandom));
         reg_cmd(4'($urandom_range(6, 15)), 16'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            reg_cmd(4'h5, 16'($urandom));
         end else begin
            load(int'($urandom_range(1, 4)));
         end
         wait_idle("drain_random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
